// File: rtl/wallace_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wallace_divider: sequential signed 16/8 restoring divider, one quotient bit
// per clock. Optional clamping on overflow via WALLACE_DIV_SATURATE_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module wallace_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dvd_q, dvd_d;   // dividend magnitude, shifts into quotient magnitude
  logic [8:0]  dvs_q, dvs_d;
  logic [8:0]  rem_q, rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  quo_q, quo_d;
  logic [7:0]  rmd_q, rmd_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic [15:0] dvd_abs;
  logic [8:0]  dvs_abs;
  logic [9:0]  rem_sh;
  logic [9:0]  trial;
  logic [15:0] q_signed;
  logic [7:0]  r_signed;
  logic        ovf_w;
  logic [7:0]  q_final;

  // A 16-bit unsigned magnitude already holds 32768 for -32768.
  assign dvd_abs  = dividend[15] ? (16'd0 - dividend) : dividend;
  assign dvs_abs  = divisor[7] ? (9'd0 - {divisor[7], divisor}) : {1'b0, divisor};
  assign rem_sh   = {rem_q, dvd_q[15]};
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign q_signed = qneg_q ? (16'd0 - dvd_q) : dvd_q;
  assign r_signed = rneg_q ? (8'd0 - rem_q[7:0]) : rem_q[7:0];
  assign ovf_w    = qneg_q ? (dvd_q > 16'd128) : (dvd_q > 16'd127);

`ifdef WALLACE_DIV_SATURATE_EN
  assign q_final = ovf_w ? (qneg_q ? 8'h80 : 8'h7F) : q_signed[7:0];
`else
  assign q_final = q_signed[7:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (divisor == 8'd0) begin
            dz_d    = 1'b1;
            dvd_d   = dividend;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            dvd_d   = dvd_abs;
            dvs_d   = dvs_abs;
            qneg_d  = dividend[15] ^ divisor[7];
            rneg_d  = dividend[15];
            cnt_d   = 4'd0;
            rem_d   = 9'd0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // Restoring step: keep the trial difference only when it is non-negative.
        rem_d = trial[9] ? rem_sh[8:0] : trial[8:0];
        dvd_d = {dvd_q[14:0], ~trial[9]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_FIX;
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          quo_d = 8'hFF;
          rmd_d = dvd_q[7:0];
          dbz_d = 1'b1;
          ovf_d = 1'b0;
        end else begin
          quo_d = q_final;
          rmd_d = r_signed;
          ovf_d = ovf_w;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      dvd_q   <= 16'd0;
      dvs_q   <= 9'd0;
      rem_q   <= 9'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= 8'd0;
      rmd_q   <= 8'd0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wallace_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wallace_divider: directed vector table plus hand sequences for reset,
// ignored start, flag clearing and a product/divisor round-trip sweep.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_wallace_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int total;
  int bad;

  wallace_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
  } vec_t;

`ifdef WALLACE_DIV_SATURATE_EN
  localparam logic [7:0] Q_1000_3   = 8'h7F;
  localparam logic [7:0] Q_8000_FF  = 8'h7F;
  localparam logic [7:0] Q_7FFF_7F  = 8'h7F;
  localparam logic [7:0] Q_M1032_8  = 8'h80;
`else
  localparam logic [7:0] Q_1000_3   = 8'h4D;
  localparam logic [7:0] Q_8000_FF  = 8'h00;
  localparam logic [7:0] Q_7FFF_7F  = 8'h02;
  localparam logic [7:0] Q_M1032_8  = 8'h7F;
`endif

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  // Drive a request and return #1 after the edge that accepts it.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges until done is seen, with a bound; returns sampled in the done cycle.
  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (n == 1 && done !== 1'b1) chk({nm, " busy@1"}, {15'd0, busy}, 16'd1);
      if (n == 16) chk({nm, " busy@16"}, {15'd0, busy}, 16'd1);
    end
  endtask

  task automatic check_result(input string nm, input vec_t v);
    chk({nm, " quotient"},    {8'd0, quotient},     {8'd0, v.q});
    chk({nm, " remainder"},   {8'd0, remainder},    {8'd0, v.r});
    chk({nm, " div_by_zero"}, {15'd0, div_by_zero}, {15'd0, v.dz});
    chk({nm, " overflow"},    {15'd0, overflow},    {15'd0, v.ov});
  endtask

  vec_t vecs[14];

  initial begin
    int   n;
    int   ai, bi, p;
    logic seen;
    vec_t v;

    total = 0;
    bad   = 0;

    vecs[0]  = '{16'd100,  8'd7,   8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{16'hFF9C, 8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{16'd16384, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{16'd1000, 8'd3,   Q_1000_3, 8'h01, 1'b0, 1'b1};
    vecs[4]  = '{16'h8000, 8'hFF,  Q_8000_FF, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{16'h1234, 8'h00,  8'hFF, 8'h34, 1'b1, 1'b0};
    vecs[6]  = '{16'd100,  8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0};
    vecs[7]  = '{16'hFF9C, 8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0};
    vecs[8]  = '{16'h7FFF, 8'h7F,  Q_7FFF_7F, 8'h01, 1'b0, 1'b1};
    vecs[9]  = '{16'hFBF8, 8'd8,   Q_M1032_8, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{16'hFC00, 8'd8,   8'h80, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{16'd0,    8'd5,   8'h00, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{16'd5,    8'h80,  8'h00, 8'h05, 1'b0, 1'b0};
    vecs[13] = '{16'hFFFB, 8'd100, 8'h00, 8'hFB, 1'b0, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",   {15'd0, busy}, 16'd0);
    chk("reset done",   {15'd0, done}, 16'd0);
    chk("reset result", {quotient, remainder}, 16'd0);
    chk("reset flags",  {14'd0, div_by_zero, overflow}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: each request is issued in the previous done cycle (back-to-back).
    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), n);
      chk($sformatf("vec%0d latency", i), n[15:0], vecs[i].dz ? 16'd1 : 16'd17);
      chk($sformatf("vec%0d busy at done", i), {15'd0, busy}, 16'd0);
      check_result($sformatf("vec%0d", i), vecs[i]);
    end

    // done is a single-cycle pulse and results hold afterwards.
    @(posedge clk);
    #1;
    chk("done pulse width", {15'd0, done}, 16'd0);
    check_result("hold", vecs[13]);

    // Flags clear on the accepted start that follows a divide-by-zero.
    start_op(16'h1234, 8'h00);
    wait_done("dz2", n);
    chk("dz2 flag", {15'd0, div_by_zero}, 16'd1);
    start_op(16'd100, 8'd7);
    chk("flag cleared at start", {15'd0, div_by_zero}, 16'd0);
    chk("result held at start", {8'd0, quotient}, 16'h00FF);
    wait_done("after dz", n);
    check_result("after dz", vecs[0]);

    // Start during busy is ignored.
    start_op(16'd100, 8'd7);
    repeat (3) @(posedge clk);
    start_op(16'd50, 8'd5);
    wait_done("busy start", n);
    chk("busy start latency", n[15:0] + 16'd4, 16'd17);
    check_result("busy start", vecs[0]);
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1 if (done) seen = 1'b1;
    end
    chk("no queued done", {15'd0, seen}, 16'd0);

    // Reset mid-calculation abandons the operation.
    start_op(16'hFF9C, 8'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst busy/done", {14'd0, busy, done}, 16'd0);
    chk("midrst result", {quotient, remainder}, 16'd0);
    chk("midrst flags", {14'd0, div_by_zero, overflow}, 16'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1'b1;
    end
    chk("midrst no done", {15'd0, seen}, 16'd0);

    // Round trip: (a*b)/b == a with zero remainder.
    for (int k = 0; k < 16; k++) begin
      ai = int'($urandom_range(0, 255)) - 128;
      bi = int'($urandom_range(1, 255)) - 128;
      if (bi == 0) bi = 1;
      p  = ai * bi;
      v.a  = p[15:0];
      v.b  = bi[7:0];
      v.q  = ai[7:0];
      v.r  = 8'h00;
      v.dz = 1'b0;
      v.ov = 1'b0;
      start_op(v.a, v.b);
      wait_done($sformatf("rnd%0d", k), n);
      chk($sformatf("rnd%0d latency", k), n[15:0], 16'd17);
      check_result($sformatf("rnd%0d a=%0d b=%0d", k, ai, bi), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
